// File: rtl/fc_pkg.sv
// Shared constants for the full_connect input sequencer: default sizes, state
// encoding and the channel-activity rule for the skewed replay.
package fc_pkg;

    localparam int LENGTH_FC   = 64;
    localparam int DATA_WIDTH  = 16;
    localparam int FILTERBATCH = 4;
    localparam int W_BEATS     = 4 * LENGTH_FC + 1;

    localparam logic [2:0] W_IDLE    = 3'd0;
    localparam logic [2:0] W_LOAD    = 3'd1;
    localparam logic [2:0] FILL      = 3'd2;
    localparam logic [2:0] STREAM    = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;

    // Channel k replays its samples k cycles after channel 0.
    function automatic logic chan_active(input int t, input int k, input int len);
        return (t >= k) && ((t - k) <= (len - 1));
    endfunction

endpackage

// File: rtl/fc_feature_buf.sv
// Frame buffer: 4 banks of LENGTH_FC samples, one write port and four
// independent combinational read ports (one per channel).
module fc_feature_buf #(
    parameter int LENGTH_FC  = 64,
    parameter int DATA_WIDTH = 16,
    localparam int IW        = $clog2(LENGTH_FC)
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [1:0]                 wr_ch,
    input  logic [IW-1:0]              wr_idx,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic [3:0][IW-1:0]         rd_idx,
    output logic [3:0][DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [4][LENGTH_FC];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ch][wr_idx] <= wr_data;
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rd_data[k] = mem[k][rd_idx[k]];
        end
    end

endmodule

// File: rtl/fc_input_sequencer.sv
// Transmit side of the full_connect input interface: one-shot weight/bias load,
// then a buffer-and-replay loop emitting four skewed channel streams per frame.
module fc_input_sequencer #(
    parameter int LENGTH_FC  = fc_pkg::LENGTH_FC,
    parameter int DATA_WIDTH = fc_pkg::DATA_WIDTH,
    localparam int AW        = $clog2(4 * LENGTH_FC + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_start,
    output logic [AW-1:0]         w_addr,
    input  logic [DATA_WIDTH-1:0] w_rdata,
    output logic [DATA_WIDTH-1:0] weight,
    output logic [DATA_WIDTH-1:0] bias,
    output logic                  weight_valid,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  ivalid1,
    output logic                  ivalid2,
    output logic                  ivalid3,
    output logic                  ivalid4,
    output logic [DATA_WIDTH-1:0] data1,
    output logic [DATA_WIDTH-1:0] data2,
    output logic [DATA_WIDTH-1:0] data3,
    output logic [DATA_WIDTH-1:0] data4,
    output logic                  start_to_cal,
    input  logic                  fc_done,
    output logic                  busy,
    output logic                  overflow,
    output logic [2:0]            state_dbg
);

    import fc_pkg::*;

    localparam int IW = $clog2(LENGTH_FC);
    localparam int TW = $clog2(LENGTH_FC + 3);
    localparam logic [AW-1:0] LAST_ADDR = AW'(4 * LENGTH_FC);
    localparam logic [TW-1:0] LAST_T    = TW'(LENGTH_FC + 2);
    localparam logic [IW-1:0] LAST_IDX  = IW'(LENGTH_FC - 1);

    logic [2:0]                  state;
    logic                        addr_done;
    logic                        last_beat;
    logic [1:0]                  wr_ch;
    logic [IW-1:0]               wr_idx;
    logic [TW-1:0]               t;
    logic                        fill_we;
    logic                        fill_last;
    logic                        stream_nxt;
    logic [TW-1:0]               t_nxt;
    logic [3:0]                  act_nxt;
    logic [3:0][IW-1:0]          rd_idx;
    logic [3:0][DATA_WIDTH-1:0]  rd_data;

    // Upstream handshake: a sample transfers on a cycle with in_valid && in_ready;
    // in_valid without in_ready drops the sample and latches overflow.
    assign in_ready  = (state == FILL);
    assign busy      = (state != W_IDLE) && (state != FILL);
    assign fill_we   = in_valid && in_ready;
    assign fill_last = fill_we && (wr_ch == 2'd3) && (wr_idx == LAST_IDX);
    assign state_dbg = state;

    assign weight = weight_valid ? w_rdata : '0;
    assign bias   = (weight_valid && last_beat) ? w_rdata : '0;

    // Stream outputs are registered, so they are computed from the next t.
    always_comb begin
        stream_nxt = 1'b0;
        t_nxt      = '0;
        if (fill_last) begin
            stream_nxt = 1'b1;
        end else if ((state == STREAM) && (t != LAST_T)) begin
            stream_nxt = 1'b1;
            t_nxt      = t + TW'(1);
        end
        for (int k = 0; k < 4; k++) begin
            act_nxt[k] = stream_nxt && chan_active(int'(t_nxt), k, LENGTH_FC);
            rd_idx[k]  = act_nxt[k] ? IW'(int'(t_nxt) - k) : '0;
        end
    end

    fc_feature_buf #(
        .LENGTH_FC  (LENGTH_FC),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk     (clk),
        .we      (fill_we),
        .wr_ch   (wr_ch),
        .wr_idx  (wr_idx),
        .wr_data (in_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= W_IDLE;
            w_addr       <= '0;
            addr_done    <= 1'b0;
            last_beat    <= 1'b0;
            weight_valid <= 1'b0;
            wr_ch        <= '0;
            wr_idx       <= '0;
            t            <= '0;
        end else begin
            case (state)
                W_IDLE: begin
                    if (w_start) state <= W_LOAD;
                end
                W_LOAD: begin
                    // Address phase leads the data phase by one cycle (ROM latency).
                    if (!addr_done) begin
                        weight_valid <= 1'b1;
                        last_beat    <= (w_addr == LAST_ADDR);
                        if (w_addr == LAST_ADDR) begin
                            addr_done <= 1'b1;
                            w_addr    <= '0;
                        end else begin
                            w_addr <= w_addr + AW'(1);
                        end
                    end else begin
                        weight_valid <= 1'b0;
                        last_beat    <= 1'b0;
                        addr_done    <= 1'b0;
                        state        <= FILL;
                    end
                end
                FILL: begin
                    if (fill_we) begin
                        if (wr_idx == LAST_IDX) begin
                            wr_idx <= '0;
                            wr_ch  <= wr_ch + 2'd1;
                        end else begin
                            wr_idx <= wr_idx + IW'(1);
                        end
                    end
                    if (fill_last) begin
                        state <= STREAM;
                        t     <= '0;
                    end
                end
                STREAM: begin
                    if (t == LAST_T) begin
                        state <= WAIT_DONE;
                        t     <= '0;
                    end else begin
                        t <= t + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (fc_done) begin
                        state  <= FILL;
                        wr_ch  <= '0;
                        wr_idx <= '0;
                    end
                end
                default: state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow     <= 1'b0;
            start_to_cal <= 1'b0;
            ivalid1      <= 1'b0;
            ivalid2      <= 1'b0;
            ivalid3      <= 1'b0;
            ivalid4      <= 1'b0;
            data1        <= '0;
            data2        <= '0;
            data3        <= '0;
            data4        <= '0;
        end else begin
            if (in_valid && !in_ready) overflow <= 1'b1;
            start_to_cal <= fill_last;
            ivalid1      <= act_nxt[0];
            ivalid2      <= act_nxt[1];
            ivalid3      <= act_nxt[2];
            ivalid4      <= act_nxt[3];
            data1        <= act_nxt[0] ? rd_data[0] : '0;
            data2        <= act_nxt[1] ? rd_data[1] : '0;
            data3        <= act_nxt[2] ? rd_data[2] : '0;
            data4        <= act_nxt[3] ? rd_data[3] : '0;
        end
    end

endmodule

// File: tb/tb_fc_input_sequencer.sv
// Directed bench for fc_input_sequencer with LENGTH_FC=4 and a 1-cycle ROM
// holding mem[a] = a+1.
module tb_fc_input_sequencer;

    localparam int L  = 4;
    localparam int DW = 16;
    localparam int AW = $clog2(4 * L + 1);

    localparam logic [2:0] S_W_IDLE    = 3'd0;
    localparam logic [2:0] S_W_LOAD    = 3'd1;
    localparam logic [2:0] S_FILL      = 3'd2;
    localparam logic [2:0] S_STREAM    = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          w_start = 1'b0;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_rdata = '0;
    logic [DW-1:0] weight, bias;
    logic          weight_valid;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          ivalid1, ivalid2, ivalid3, ivalid4;
    logic [DW-1:0] data1, data2, data3, data4;
    logic          start_to_cal;
    logic          fc_done = 1'b0;
    logic          busy;
    logic          overflow;
    logic [2:0]    state_dbg;

    logic [3:0]          iv_out;
    logic [3:0][DW-1:0]  d_out;
    assign iv_out = {ivalid4, ivalid3, ivalid2, ivalid1};
    assign d_out  = {data4, data3, data2, data1};

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];
    bit exp_ovf = 1'b0;

    typedef struct packed {
        logic               inj_valid;
        logic               inj_wstart;
        logic               stc;
        logic [3:0]         iv;
        logic [3:0][DW-1:0] d;
    } vec_t;
    vec_t vec [7];

    // ---- clock / ROM ----
    always #5 clk = ~clk;

    always @(posedge clk) w_rdata <= DW'(w_addr) + DW'(1);

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    fc_input_sequencer #(.LENGTH_FC(L), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .w_start      (w_start),
        .w_addr       (w_addr),
        .w_rdata      (w_rdata),
        .weight       (weight),
        .bias         (bias),
        .weight_valid (weight_valid),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .ivalid1      (ivalid1),
        .ivalid2      (ivalid2),
        .ivalid3      (ivalid3),
        .ivalid4      (ivalid4),
        .data1        (data1),
        .data2        (data2),
        .data3        (data3),
        .data4        (data4),
        .start_to_cal (start_to_cal),
        .fc_done      (fc_done),
        .busy         (busy),
        .overflow     (overflow),
        .state_dbg    (state_dbg)
    );

    // ---- scoreboard ----
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_w_addr"}, 32'(w_addr), 0);
        check({tag, "_weight"}, 32'(weight), 0);
        check({tag, "_bias"}, 32'(bias), 0);
        check({tag, "_wvalid"}, 32'(weight_valid), 0);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_ivalid"}, 32'(iv_out), 0);
        check({tag, "_data12"}, {data2, data1}, 0);
        check({tag, "_data34"}, {data4, data3}, 0);
        check({tag, "_stc"}, 32'(start_to_cal), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_overflow"}, 32'(overflow), 0);
        check({tag, "_state"}, 32'(state_dbg), 32'(S_W_IDLE));
    endtask

    // ---- drivers ----
    // Called at a negedge in W_IDLE; returns at the negedge of the first FILL cycle.
    task automatic weight_load(input string tag);
        logic [DW-1:0] e;
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        check({tag, "_addr0"}, 32'(w_addr), 0);
        check({tag, "_wv_pre"}, 32'(weight_valid), 0);
        check({tag, "_state_load"}, 32'(state_dbg), 32'(S_W_LOAD));
        for (int b = 0; b < 17; b++) exp_q.push_back(DW'(b + 1));
        for (int b = 0; b < 17; b++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("%s_wv_b%0d", tag, b), 32'(weight_valid), 1);
            if (b < 16) begin
                check($sformatf("%s_weight_b%0d", tag, b), 32'(weight), 32'(e));
                check($sformatf("%s_bias_b%0d", tag, b), 32'(bias), 0);
            end else begin
                check($sformatf("%s_bias_last", tag), 32'(bias), 32'(e));
            end
        end
        @(negedge clk);
        check({tag, "_wv_post"}, 32'(weight_valid), 0);
        check({tag, "_bias_post"}, 32'(bias), 0);
        check({tag, "_state_fill"}, 32'(state_dbg), 32'(S_FILL));
        check({tag, "_in_ready"}, 32'(in_ready), 1);
    endtask

    // Called at a negedge in FILL; the last sample is still driven on return.
    task automatic fill_frame(input logic [DW-1:0] base, input bit spurious, input string tag);
        check({tag, "_fill_ready"}, 32'(in_ready), 1);
        for (int i = 0; i < 4 * L; i++) begin
            if (i > 0) @(negedge clk);
            if (spurious && i == 6) check({tag, "_fill_state_after_done"}, 32'(state_dbg), 32'(S_FILL));
            in_valid = 1'b1;
            in_data  = base + DW'(16'h10 * (i / L)) + DW'(i % L);
            fc_done  = spurious && (i == 5);
        end
    endtask

    task automatic run_stream(input logic [DW-1:0] base, input bit inj, input int stop_t, input string tag);
        logic [DW-1:0] ed;
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            check($sformatf("%s_t%0d_state", tag, t), 32'(state_dbg), 32'(S_STREAM));
            check($sformatf("%s_t%0d_ivalid", tag, t), 32'(iv_out), 32'(vec[t].iv));
            for (int k = 0; k < 4; k++) begin
                ed = vec[t].iv[k] ? vec[t].d[k] + base : '0;
                check($sformatf("%s_t%0d_data%0d", tag, t, k + 1), 32'(d_out[k]), 32'(ed));
            end
            check($sformatf("%s_t%0d_stc", tag, t), 32'(start_to_cal), 32'(vec[t].stc));
            check($sformatf("%s_t%0d_wvalid", tag, t), 32'(weight_valid), 0);
            check($sformatf("%s_t%0d_overflow", tag, t), 32'(overflow), 32'(exp_ovf));
            if (t == stop_t) return;
            in_valid = inj && vec[t].inj_valid;
            in_data  = 16'hdead;
            w_start  = inj && vec[t].inj_wstart;
            fc_done  = 1'b0;
            if (in_valid) exp_ovf = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        w_start  = 1'b0;
        check({tag, "_wait_state"}, 32'(state_dbg), 32'(S_WAIT_DONE));
        check({tag, "_wait_ivalid"}, 32'(iv_out), 0);
        check({tag, "_wait_busy"}, 32'(busy), 1);
        check({tag, "_wait_stc"}, 32'(start_to_cal), 0);
    endtask

    task automatic finish_frame(input string tag);
        fc_done = 1'b1;
        @(negedge clk);
        fc_done = 1'b0;
        check({tag, "_ready_back"}, 32'(in_ready), 1);
        check({tag, "_state_back"}, 32'(state_dbg), 32'(S_FILL));
        check({tag, "_no_reload"}, 32'(weight_valid), 0);
        check({tag, "_overflow_end"}, 32'(overflow), 32'(exp_ovf));
    endtask

    // ---- test ----
    initial begin
        //        inj_v inj_w stc  ivalid   data4     data3     data2     data1
        vec[0] = '{1'b0, 1'b0, 1'b1, 4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h0000}};
        vec[1] = '{1'b0, 1'b0, 1'b0, 4'b0011, {16'h0000, 16'h0000, 16'h0010, 16'h0001}};
        vec[2] = '{1'b1, 1'b0, 1'b0, 4'b0111, {16'h0000, 16'h0020, 16'h0011, 16'h0002}};
        vec[3] = '{1'b0, 1'b0, 1'b0, 4'b1111, {16'h0030, 16'h0021, 16'h0012, 16'h0003}};
        vec[4] = '{1'b0, 1'b1, 1'b0, 4'b1110, {16'h0031, 16'h0022, 16'h0013, 16'h0000}};
        vec[5] = '{1'b0, 1'b0, 1'b0, 4'b1100, {16'h0032, 16'h0023, 16'h0000, 16'h0000}};
        vec[6] = '{1'b0, 1'b0, 1'b0, 4'b1000, {16'h0033, 16'h0000, 16'h0000, 16'h0000}};

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_state", 32'(state_dbg), 32'(S_W_IDLE));

        // Frame 1: clean weight load and stream.
        weight_load("wload1");
        fill_frame(16'h0000, 1'b0, "f1");
        run_stream(16'h0000, 1'b0, 99, "f1");
        finish_frame("f1");

        // Frame 2: in_valid and w_start injected during STREAM.
        fill_frame(16'h0100, 1'b0, "f2");
        run_stream(16'h0100, 1'b1, 99, "f2");
        finish_frame("f2");

        // Frame 3: spurious fc_done while filling.
        fill_frame(16'h0200, 1'b1, "f3");
        run_stream(16'h0200, 1'b0, 99, "f3");
        finish_frame("f3");

        // Frame 4: reset asserted at t=2.
        fill_frame(16'h0300, 1'b0, "f4");
        run_stream(16'h0300, 1'b0, 2, "f4");
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        exp_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        weight_load("wload2");
        fill_frame(16'h0400, 1'b0, "f5");
        run_stream(16'h0400, 1'b0, 99, "f5");
        finish_frame("f5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
